uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_CY_PER_BIT, default 87, gives i_clk cycles per serial bit (10 MHz clock, 115200 baud); SHALL be >= 4.
REQ-002 i_clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 i_rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-004 i_Rx_Serial  input  1  asynchronous serial line; idles high; driven by uart_tx o_Tx_Serial.
REQ-005 o_Rx_Dv  output  1  one-cycle pulse marking a received frame.
REQ-006 o_Rx_Byte  output  8  received data byte; valid while o_Rx_Dv is high, then held.
REQ-007 o_Rx_Active  output  1  high while a frame is being received.
REQ-008 o_Parity_Err  output  1  parity mismatch flag for the current or most recent frame.
REQ-009 o_Framing_Err  output  1  stop-bit-low flag for the current or most recent frame.

Function
REQ-010 i_Rx_Serial SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-011 Frame format SHALL be: start (0), 8 data bits LSB first, even parity bit (XOR of the 8 data bits) when enabled, stop (1). This SHALL match uart_tx.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and CLEANUP.
REQ-013 IDLE: a synchronized 0 SHALL move the FSM to START, clear the bit counter and assert o_Rx_Active.
REQ-014 START: after (CLK_CY_PER_BIT-1)/2 cycles (43 for 87), the line SHALL be resampled.
  - Low: go to DATA.
  - High: false start; return to IDLE and deassert o_Rx_Active; no o_Rx_Dv.
REQ-015 DATA: each bit SHALL be sampled CLK_CY_PER_BIT cycles after the previous sample and shifted into bit position 0..7 in order. The 3-bit index SHALL NOT wrap past bit 7 before the state exits.
REQ-016 PARITY: one sample CLK_CY_PER_BIT cycles later. Error = sample XOR (XOR of data bits).
REQ-017 STOP: one sample CLK_CY_PER_BIT cycles later. Framing error = sample is 0.
REQ-018 The cycle after the stop sample:
  - o_Rx_Dv SHALL pulse high for exactly 1 cycle.
  - o_Rx_Byte, o_Parity_Err and o_Framing_Err SHALL update in that same cycle.
  - The FSM SHALL enter CLEANUP.
REQ-019 o_Rx_Dv SHALL pulse even when either error flag is set.
REQ-020 CLEANUP: the FSM SHALL wait until the synchronized line reads 1 (break or stuck-low protection), then go to IDLE and deassert o_Rx_Active.
REQ-021 The error flags and o_Rx_Byte SHALL hold until the next o_Rx_Dv pulse.
REQ-022 The bit-period counter SHALL be $clog2(CLK_CY_PER_BIT) bits wide. It SHALL reset to 0 at each sample and never exceed CLK_CY_PER_BIT-1.
REQ-023 Back-to-back frames (the next start bit immediately after the stop bit) SHALL be received without loss.

Reset
REQ-024 While i_rst_n is low at a clock edge:
  - o_Rx_Dv, o_Rx_Active, o_Parity_Err and o_Framing_Err SHALL be 0.
  - o_Rx_Byte, the shift register and all counters SHALL be 0.
  - The FSM SHALL be IDLE and the synchronizer flops SHALL be 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no o_Rx_Dv pulse. After release, reception SHALL resume at the next falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN controls the parity stage.
  - Defined: the PARITY state and check exist as described.
  - Undefined: DATA SHALL go directly to STOP, the frame is 10 bits, and o_Parity_Err SHALL be constant 0.
REQ-027 The default build SHALL define UART_RX_PARITY_EN, because uart_tx always sends parity.

Verification (CLK_CY_PER_BIT=87, 100 ns clock, bit = 8700 ns)
REQ-028 Send 0xAA with parity 0 and stop 1 -> o_Rx_Dv single pulse, o_Rx_Byte=0xAA, both error flags 0.
REQ-029 Send 0x01 with a corrupted parity bit of 0 -> o_Rx_Byte=0x01, o_Parity_Err=1, o_Framing_Err=0.
REQ-030 Send 0x55 with stop bit 0 and the line held low 3 bit periods -> o_Framing_Err=1; o_Rx_Active stays high until the line returns high.
REQ-031 Apply a 2000 ns low glitch on the idle line -> no o_Rx_Dv; o_Rx_Active returns to 0 within 45 cycles.
REQ-032 Drive i_rst_n low for 2 cycles during data bit 4 of a frame -> no o_Rx_Dv for that frame; the following frame 0x3C is received correctly.
REQ-033 Loopback uart_tx to uart_rx, sending 0x00, 0xFF and 0xA5 back-to-back -> three o_Rx_Dv pulses carrying matching bytes, with no errors.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, 8N1 or 8E1 frames.
// Define UART_RX_PARITY_EN for the even-parity stage (needed when paired with uart_tx).
module uart_rx #(
  parameter int CLK_CY_PER_BIT = 87
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_Dv,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Parity_Err,
  output logic       o_Framing_Err
);

  localparam int CNT_W = $clog2(CLK_CY_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_CY_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLK_CY_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd3;
`endif
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_CLEANUP = 3'd5;

  logic             sync_1;
  logic             rx_sync;
  logic [2:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
  logic             parity_bad;
`endif

  // NOTE: synchronizer resets to 1 so a reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_1  <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync_1  <= i_Rx_Serial;
      rx_sync <= sync_1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      clk_cnt       <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      o_Rx_Dv       <= 1'b0;
      o_Rx_Byte     <= '0;
      o_Rx_Active   <= 1'b0;
      o_Framing_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad    <= 1'b0;
      o_Parity_Err  <= 1'b0;
`endif
    end else begin
      // NOTE: default low each cycle makes o_Rx_Dv a single-cycle pulse.
      o_Rx_Dv <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          if (!rx_sync) begin
            state       <= S_START;
            bit_idx     <= '0;
            o_Rx_Active <= 1'b1;
          end
        end
        S_START: begin
          if (clk_cnt == HALF_BIT) begin
            clk_cnt <= '0;
            if (!rx_sync) begin
              state <= S_DATA;
            end else begin
              state       <= S_IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_sync;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt    <= '0;
            parity_bad <= rx_sync ^ (^shift);
            state      <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt       <= '0;
            o_Rx_Dv       <= 1'b1;
            o_Rx_Byte     <= shift;
            o_Framing_Err <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
            o_Parity_Err  <= parity_bad;
`endif
            state         <= S_CLEANUP;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        S_CLEANUP: begin
          // A low stop bit may mean a break; wait for the line to recover.
          if (rx_sync) begin
            state       <= S_IDLE;
            o_Rx_Active <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_Parity_Err = 1'b0;
`endif

endmodule
